// File: rtl/hvac_pkg.sv
// Shared definitions for the thermostat plant: sequencer state encoding and
// temperature format (signed, LSB = 1/16 degC).
package hvac_pkg;

    localparam int TEMP_W_DEF     = 12;
    localparam int TEMP_FRAC_BITS = 4;   // 2**-4 degC per LSB

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_HEAT    = 2'b01,
        S_COOL    = 2'b10,
        S_LOCKOUT = 2'b11
    } hvac_state_t;

endpackage

// File: rtl/hvac_dwell_timer.sv
// Saturating up-counter measuring how long the sequencer has sat in its
// current state; cleared synchronously on every state change.
module hvac_dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hvac_sequencer.sv
// Heat/cool sequencer: deadband decision, minimum on-time, post-run lockout,
// registered mutually exclusive actuator enables.
module hvac_sequencer
    import hvac_pkg::*;
#(
    parameter int TEMP_W  = TEMP_W_DEF,
    parameter int MIN_ON  = 16,
    parameter int MIN_OFF = 8,
    parameter int CNT_W   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     temp_valid,
    input  logic signed [TEMP_W-1:0] temp,
    input  logic signed [TEMP_W-1:0] setpoint,
    input  logic        [TEMP_W-2:0] band,
    output logic                     heat_en,
    output logic                     cool_en,
    output logic        [1:0]        state
);

    hvac_state_t state_q, state_d;
    logic heat_d, cool_d;
    logic [CNT_W-1:0] dwell;

    // One extra bit keeps setpoint +/- band exact over the full input range.
    logic signed [TEMP_W:0] temp_x, sp_x, band_x, low, high;

    assign temp_x = {temp[TEMP_W-1], temp};
    assign sp_x   = {setpoint[TEMP_W-1], setpoint};
    assign band_x = signed'({2'b00, band});
    assign low    = sp_x - band_x;
    assign high   = sp_x + band_x;

    logic want_heat, want_cool, min_on_met, lock_done;

    assign want_heat  = enable && temp_valid && (temp_x < low);
    assign want_cool  = enable && temp_valid && (temp_x > high);
    assign min_on_met = (dwell >= CNT_W'(MIN_ON - 1));
    assign lock_done  = (dwell == CNT_W'(MIN_OFF - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            heat_en <= 1'b0;
            cool_en <= 1'b0;
        end else begin
            state_q <= state_d;
            heat_en <= heat_d;
            cool_en <= cool_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (want_heat)      state_d = S_HEAT;
                else if (want_cool) state_d = S_COOL;
            end
            S_HEAT: begin
                if (!enable)
                    state_d = S_LOCKOUT;
                else if (temp_valid && (temp_x >= sp_x) && min_on_met)
                    state_d = S_LOCKOUT;
            end
            S_COOL: begin
                if (!enable)
                    state_d = S_LOCKOUT;
                else if (temp_valid && (temp_x <= sp_x) && min_on_met)
                    state_d = S_LOCKOUT;
            end
            S_LOCKOUT: begin
                if (lock_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Enables are decoded from the next state so they register with it.
    always_comb begin
        heat_d = (state_d == S_HEAT);
        cool_d = (state_d == S_COOL);
    end

    hvac_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clock (clock),
        .reset (reset),
        .clear (state_d != state_q),
        .count (dwell)
    );

    assign state = state_q;

endmodule

// File: tb/tb_hvac_sequencer.sv
// Self-checking bench for hvac_sequencer: directed scenarios followed by
// randomized traffic, compared against a duration-based behavioural model.
module tb_hvac_sequencer;

    localparam int TEMP_W  = 12;
    localparam int MIN_ON  = 16;
    localparam int MIN_OFF = 8;
    localparam int CNT_W   = 8;

    localparam int M_IDLE = 0, M_HEAT = 1, M_COOL = 2, M_LOCK = 3;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     enable;
    logic                     temp_valid;
    logic signed [TEMP_W-1:0] temp;
    logic signed [TEMP_W-1:0] setpoint;
    logic        [TEMP_W-2:0] band;
    logic                     heat_en;
    logic                     cool_en;
    logic        [1:0]        state;

    hvac_sequencer #(
        .TEMP_W  (TEMP_W),
        .MIN_ON  (MIN_ON),
        .MIN_OFF (MIN_OFF),
        .CNT_W   (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .temp_valid (temp_valid),
        .temp       (temp),
        .setpoint   (setpoint),
        .band       (band),
        .heat_en    (heat_en),
        .cool_en    (cool_en),
        .state      (state)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: current mode and how many full cycles it has already lasted.
    int m_mode = M_IDLE;
    int m_held = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int sp, t, lo, hi, nxt, nth;
        sp  = int'(setpoint);
        t   = int'(temp);
        lo  = sp - int'(band);
        hi  = sp + int'(band);
        nth = m_held + 1;   // ordinal of the cycle now in progress
        nxt = m_mode;
        case (m_mode)
            M_IDLE: begin
                if (enable && temp_valid && t < lo)      nxt = M_HEAT;
                else if (enable && temp_valid && t > hi) nxt = M_COOL;
            end
            M_HEAT: begin
                if (!enable) nxt = M_LOCK;
                else if (temp_valid && t >= sp && nth >= MIN_ON) nxt = M_LOCK;
            end
            M_COOL: begin
                if (!enable) nxt = M_LOCK;
                else if (temp_valid && t <= sp && nth >= MIN_ON) nxt = M_LOCK;
            end
            default: begin
                if (nth == MIN_OFF) nxt = M_IDLE;
            end
        endcase
        if (nxt != m_mode) begin
            m_mode = nxt;
            m_held = 0;
        end else begin
            m_held++;
        end
    endtask

    task automatic check_outputs();
        chk("state", int'(state), m_mode);
        chk("heat_en", int'(heat_en), (m_mode == M_HEAT) ? 1 : 0);
        chk("cool_en", int'(cool_en), (m_mode == M_COOL) ? 1 : 0);
        chk("exclusive", int'(heat_en & cool_en), 0);
    endtask

    task automatic step();
        model_step();
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input int t);
        temp_valid = v;
        temp       = TEMP_W'(t);
        step();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_mode != M_IDLE && n < 64) begin
            drive(1'b1, int'(setpoint));
            n++;
        end
        chk("wait_idle_bound", int'(state), M_IDLE);
    endtask

    // temp == setpoint satisfies the exit rule of either run direction.
    task automatic end_run();
        int n = 0;
        while ((m_mode == M_HEAT || m_mode == M_COOL) && n < 64) begin
            drive(1'b1, int'(setpoint));
            n++;
        end
        chk("end_run_bound", int'(state), M_LOCK);
        wait_idle();
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        temp_valid = 1'b0;
        temp       = '0;
        setpoint   = 12'sd320;
        band       = 11'd16;
        #12;
        chk("rst_state", int'(state), M_IDLE);
        chk("rst_heat", int'(heat_en), 0);
        chk("rst_cool", int'(cool_en), 0);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        enable = 1'b1;

        // Heat run with min-on boundary and exact lockout length
        drive(1'b1, 300);
        chk("s1_heat_on", int'(heat_en), 1);
        repeat (5) drive(1'b0, 0);
        drive(1'b1, 330);
        chk("s1_early_hold", int'(state), M_HEAT);
        repeat (8) drive(1'b0, 0);
        drive(1'b1, 330);
        chk("s1_cycle14_hold", int'(heat_en), 1);
        drive(1'b1, 330);
        chk("s1_cycle15_lock", int'(state), M_LOCK);
        chk("s1_heat_off", int'(heat_en), 0);
        repeat (MIN_OFF - 1) begin
            drive(1'b1, 300);
            chk("s1_in_lock", int'(state), M_LOCK);
        end
        drive(1'b1, 300);
        chk("s1_idle_after_8", int'(state), M_IDLE);

        // Cool run, heat request during lockout is ignored
        drive(1'b1, 340);
        chk("s2_cool_on", int'(cool_en), 1);
        repeat (15) drive(1'b0, 0);
        drive(1'b1, 320);
        chk("s2_lock", int'(state), M_LOCK);
        repeat (MIN_OFF) begin
            drive(1'b1, 300);
            chk("s2_no_heat", int'(heat_en), 0);
        end
        chk("s2_idle", int'(state), M_IDLE);

        // Deadband edges
        drive(1'b1, 304);
        chk("s3_low_edge", int'(state), M_IDLE);
        drive(1'b1, 336);
        chk("s3_high_edge", int'(state), M_IDLE);
        drive(1'b1, 303);
        chk("s3_below_low", int'(state), M_HEAT);
        end_run();
        drive(1'b1, 337);
        chk("s3_above_high", int'(state), M_COOL);
        end_run();

        // Enable abort and enable gating in IDLE
        drive(1'b1, 300);
        repeat (3) drive(1'b0, 0);
        enable = 1'b0;
        drive(1'b0, 0);
        chk("s4_abort", int'(state), M_LOCK);
        wait_idle();
        drive(1'b1, 200);
        chk("s4_disabled", int'(state), M_IDLE);
        enable = 1'b1;

        // Asynchronous reset mid-run
        drive(1'b1, 340);
        repeat (3) drive(1'b0, 0);
        #3;
        reset = 1'b1;
        #1;
        chk("s5_async_state", int'(state), M_IDLE);
        chk("s5_async_cool", int'(cool_en), 0);
        m_mode = M_IDLE;
        m_held = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(1'b1, 300);
        chk("s5_heat_after_rst", int'(heat_en), 1);
        end_run();

        // Full-range thresholds
        setpoint = 12'sd2047;
        band     = 11'd2047;
        drive(1'b1, -2048);
        chk("s6_heat_wide", int'(state), M_HEAT);
        end_run();
        setpoint = -12'sd2048;
        drive(1'b1, 2047);
        chk("s6_cool_wide", int'(state), M_COOL);
        end_run();

        // Randomized traffic
        setpoint = 12'sd320;
        band     = 11'd16;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                setpoint = TEMP_W'($urandom_range(0, 1000) - 500);
                band     = 11'($urandom_range(0, 40));
            end
            enable = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 99) == 0)
                drive(1'b1, int'($urandom_range(0, 4095)) - 2048);
            else
                drive($urandom_range(0, 2) == 0,
                      int'(setpoint) + int'($urandom_range(0, 120)) - 60);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
